hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core, replacing the purely combinational forwarding logic. It provides E-stage operand forwarding from M and W and detects load-use hazards. It issues stall and flush controls for taken branches, and sequences a fixed-latency multi-cycle multiply/divide unit in E. A saturating stall-cycle counter is exposed for performance monitoring.

## Interface
Parameters:
- REG_ADDR_BITS, 5, register address width
- MD_LATENCY, 4, total E-stage occupancy of a mul/div op in cycles; legal range is 2 or more
- CNT_BITS, 16, width of the stall performance counter

Ports:
- clk  in  1  core clock; all state on the rising edge
- reset  in  1  synchronous, active-high reset
- readRegister1D, readRegister2D  in  REG_ADDR_BITS  D-stage source registers
- readRegister1E, readRegister2E  in  REG_ADDR_BITS  E-stage source registers
- writeRegE, writeRegM, writeRegW  in  REG_ADDR_BITS  destination registers per stage
- regWriteE, regWriteM, regWriteW  in  1  destination write enables
- memToRegE  in  1  the E-stage instruction is a load
- branchTakenE  in  1  a branch or jump in E redirects the PC
- mdStartE  in  1  the E-stage instruction is a mul/div
- forwardAE, forwardBE  out  2  operand select: 00 register file, 01 W, 10 M
- stallF, stallD, stallE  out  1  hold the stage register
- flushD, flushE  out  1  insert a bubble into the stage register
- mdBusy  out  1  mul/div sequencer is counting
- mdDone  out  1  mul/div result is valid this cycle; E advances
- stallCount  out  CNT_BITS  saturating count of cycles with stallF=1

## Operation
- Forwarding (combinational):
  - For each E source r, when r != 0: select 10 if regWriteM and writeRegM == r; otherwise select 01 if regWriteW and writeRegW == r; otherwise 00.
  - r == 0 always selects 00.
  - M has priority over W.
- Load-use hazard: memToRegE & regWriteE & writeRegE != 0 & (writeRegE == readRegister1D or writeRegE == readRegister2D). Response: stallF=stallD=1, flushE=1.
- Branch: branchTakenE gives flushD=flushE=1 and no stalls. The branch wins over a load-use hazard in the same cycle.
- Mul/div sequencer states:
  - IDLE: if mdStartE, assert stallF/D/E, load the counter with MD_LATENCY-2, and go to BUSY.
  - BUSY: assert stallF/D/E and mdBusy. If the counter is 0, go to DONE; otherwise decrement.
  - DONE: mdDone=1 and no sequencer stall. mdStartE is ignored here because it is the same instruction. Go to IDLE unconditionally.
- The sequencer stall (the IDLE start cycle and all BUSY cycles) dominates every other source:
  - flushD=flushE=0.
  - branchTakenE and the load-use condition are ignored.
- stallCount increments each cycle stallF=1 and holds at 2^CNT_BITS-1.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state; there is no added latency.
- A mul/div op holds E for exactly MD_LATENCY cycles: one start cycle plus MD_LATENCY-1 BUSY cycles. DONE is the following cycle, in which the instruction advances to M.
- MD_LATENCY=2: BUSY lasts one cycle.
- While reset=1:
  - stalls, flushes, mdBusy and mdDone are 0.
  - forwarding stays combinational.
  - On the next edge the state is IDLE, the counter is 0 and stallCount is 0.
- Reset in BUSY: the next cycle is IDLE with no stall, and the in-flight op is abandoned.
- Back-to-back mul/div: a new mdStartE in the cycle after DONE, which is IDLE, starts a fresh sequence.

## Configuration
- HAZARD_MULDIV_EN defined: the sequencer, counter, mdBusy and mdDone are built as described.
- HAZARD_MULDIV_EN undefined:
  - No sequencer state exists.
  - mdStartE is ignored.
  - mdBusy=mdDone=0.
  - Stalls come only from load-use hazards.

## Test plan
- Forwarding: readRegister1E=5, writeRegM=5, regWriteM=1, writeRegW=5, regWriteW=1 -> forwardAE=10. Repeat with all register fields =0 and both enables set -> forwardAE=00.
- Load-use: memToRegE=1, regWriteE=1, writeRegE=7, readRegister2D=7 -> stallF=stallD=flushE=1 for one cycle. Add branchTakenE=1 -> flushD=flushE=1, stallF=0.
- Mul/div with MD_LATENCY=4: pulse mdStartE high and hold it -> stallE=1 for 4 cycles, mdBusy=1 for 3 cycles, then mdDone=1 for one cycle, then IDLE. stallCount increases by 4.
- Priority: branchTakenE=1 during BUSY -> flushD=flushE=0, stalls stay 1.
- Reset at the second BUSY cycle -> the next cycle has all stalls 0, mdBusy=0 and stallCount=0.
- Saturation with CNT_BITS=4: hold a load-use hazard for 20 cycles -> stallCount=15. Build without HAZARD_MULDIV_EN: mdStartE=1 -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch stall+flush, mul/div sequencing.
// Define HAZARD_MULDIV_EN to build the multi-cycle mul/div sequencer.
module hazard_ctrl #(
    parameter int REG_ADDR_BITS = 5,
    parameter int MD_LATENCY    = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_ADDR_BITS-1:0] readRegister1D,
    input  logic [REG_ADDR_BITS-1:0] readRegister2D,
    input  logic [REG_ADDR_BITS-1:0] readRegister1E,
    input  logic [REG_ADDR_BITS-1:0] readRegister2E,
    input  logic [REG_ADDR_BITS-1:0] writeRegE,
    input  logic [REG_ADDR_BITS-1:0] writeRegM,
    input  logic [REG_ADDR_BITS-1:0] writeRegW,
    input  logic                     regWriteE,
    input  logic                     regWriteM,
    input  logic                     regWriteW,
    input  logic                     memToRegE,
    input  logic                     branchTakenE,
    input  logic                     mdStartE,
    output logic [1:0]               forwardAE,
    output logic [1:0]               forwardBE,
    output logic                     stallF,
    output logic                     stallD,
    output logic                     stallE,
    output logic                     flushD,
    output logic                     flushE,
    output logic                     mdBusy,
    output logic                     mdDone,
    output logic [CNT_BITS-1:0]      stallCount
);

    assign forwardAE =
        (readRegister1E == '0) ? 2'b00 :
        (regWriteM && writeRegM == readRegister1E) ? 2'b10 :
        (regWriteW && writeRegW == readRegister1E) ? 2'b01 : 2'b00;

    assign forwardBE =
        (readRegister2E == '0) ? 2'b00 :
        (regWriteM && writeRegM == readRegister2E) ? 2'b10 :
        (regWriteW && writeRegW == readRegister2E) ? 2'b01 : 2'b00;

    logic loadUse;
    logic seqStall;

    assign loadUse = memToRegE && regWriteE && (writeRegE != '0) &&
                     (writeRegE == readRegister1D || writeRegE == readRegister2D);

`ifdef HAZARD_MULDIV_EN
    localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

    mdState_t      state;
    logic [CW-1:0] mdCount;
    logic          busyQ;
    logic          doneQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mdCount <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdStartE) begin
                        state   <= BUSY;
                        mdCount <= CW'(MD_LATENCY - 2);
                        busyQ   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mdCount == '0) begin
                        state <= DONE;
                        busyQ <= 1'b0;
                        doneQ <= 1'b1;
                    end else begin
                        mdCount <= mdCount - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    doneQ <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                end
            endcase
        end
    end

    // The start cycle already holds E, before BUSY is entered.
    assign seqStall = !reset &&
                      ((state == IDLE && mdStartE) || state == BUSY);
    assign mdBusy   = busyQ && !reset;
    assign mdDone   = doneQ && !reset;
`else
    logic unusedMd;

    assign unusedMd = mdStartE ^ (MD_LATENCY < 2);
    assign seqStall = 1'b0;
    assign mdBusy   = 1'b0;
    assign mdDone   = 1'b0;
`endif

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (reset) begin
            stallF = 1'b0;
        end else if (seqStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
        end else if (branchTakenE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stallF && stallCount != '1) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps plus random traffic
// compared against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int RB = 5;
    localparam int L  = 4;
    localparam int CB = 4;
    localparam int CMAX = (1 << CB) - 1;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [RB-1:0] rr1D, rr2D, rr1E, rr2E;
    logic [RB-1:0] wrE, wrM, wrW;
    logic          rwE, rwM, rwW, memToRegE, branchTakenE, mdStartE;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, stallE, flushD, flushE, mdBusy, mdDone;
    logic [CB-1:0] stallCount;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles into the current mul/div op (0 = none,
    // L = the DONE cycle) and the stall counter.
    int mOcc = 0;
    int mCnt = 0;

    hazard_ctrl #(.REG_ADDR_BITS(RB), .MD_LATENCY(L), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .readRegister1D(rr1D), .readRegister2D(rr2D),
        .readRegister1E(rr1E), .readRegister2E(rr2E),
        .writeRegE(wrE), .writeRegM(wrM), .writeRegW(wrW),
        .regWriteE(rwE), .regWriteM(rwM), .regWriteW(rwW),
        .memToRegE(memToRegE), .branchTakenE(branchTakenE),
        .mdStartE(mdStartE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .mdBusy(mdBusy), .mdDone(mdDone), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [RB-1:0] r);
        if (r == 0) return 2'b00;
        if (rwM && wrM == r) return 2'b10;
        if (rwW && wrW == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clearIn();
        reset = 1'b0;
        rr1D = '0; rr2D = '0; rr1E = '0; rr2E = '0;
        wrE = '0; wrM = '0; wrW = '0;
        rwE = 1'b0; rwM = 1'b0; rwW = 1'b0;
        memToRegE = 1'b0; branchTakenE = 1'b0; mdStartE = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit seq, busy, done, lu, sF, sD, sE, fD, fE;
        @(negedge clk);
        busy = MD && !reset && mOcc >= 1 && mOcc <= L - 1;
        done = MD && !reset && mOcc == L;
        seq  = busy || (MD && !reset && mOcc == 0 && mdStartE);
        lu   = memToRegE && rwE && wrE != 0 && (wrE == rr1D || wrE == rr2D);
        sF = 0; sD = 0; sE = 0; fD = 0; fE = 0;
        if (!reset) begin
            if (seq) begin
                sF = 1; sD = 1; sE = 1;
            end else if (branchTakenE) begin
                fD = 1; fE = 1;
            end else if (lu) begin
                sF = 1; sD = 1; fE = 1;
            end
        end
        check("forwardAE", 32'(forwardAE), 32'(fwdRef(rr1E)));
        check("forwardBE", 32'(forwardBE), 32'(fwdRef(rr2E)));
        check("stallF", 32'(stallF), 32'(sF));
        check("stallD", 32'(stallD), 32'(sD));
        check("stallE", 32'(stallE), 32'(sE));
        check("flushD", 32'(flushD), 32'(fD));
        check("flushE", 32'(flushE), 32'(fE));
        check("mdBusy", 32'(mdBusy), 32'(busy));
        check("mdDone", 32'(mdDone), 32'(done));
        check("stallCount", 32'(stallCount), 32'(mCnt));
        @(posedge clk);
        if (reset) begin
            mOcc = 0;
            mCnt = 0;
        end else begin
            if (sF && mCnt < CMAX) mCnt++;
            if (MD) begin
                if (mOcc == 0) mOcc = mdStartE ? 1 : 0;
                else if (mOcc == L) mOcc = 0;
                else mOcc++;
            end
        end
        #1;
    endtask

    initial begin
        clearIn();
        reset = 1'b1;
        rr1E = 5; wrM = 5; rwM = 1; wrW = 5; rwW = 1;
        step();
        step();
        reset = 1'b0;

        // M beats W; r0 never forwards.
        step();
        check("fwdM_over_W", 32'(forwardAE), 32'(2'b10));
        rr1E = 0; rr2E = 0; wrM = 0; wrW = 0;
        step();
        check("fwd_r0", 32'(forwardAE), 32'(2'b00));
        rr2E = 9; wrW = 9; wrM = 3;
        step();
        check("fwdW", 32'(forwardBE), 32'(2'b01));
        clearIn();

        // Load-use, then branch overriding it.
        memToRegE = 1; rwE = 1; wrE = 7; rr2D = 7;
        step();
        check("lu_stallF", 32'(stallF), 32'd1);
        branchTakenE = 1;
        step();
        check("br_over_lu_stallF", 32'(stallF), 32'd0);
        check("br_over_lu_flushD", 32'(flushD), 32'd1);
        clearIn();
        wrE = 0; memToRegE = 1; rwE = 1; rr1D = 0;
        step();
        clearIn();

        // Mul/div held high: start, busy, done, then a fresh start.
        reset = 1'b1;
        step();
        reset = 1'b0;
        mdStartE = 1;
        repeat (3) step();
        branchTakenE = 1;
        repeat (3) step();
        branchTakenE = 0;
        mdStartE = 0;
        repeat (4) step();

        // Reset landing on the second BUSY cycle.
        mdStartE = 1;
        step();
        mdStartE = 0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("post_reset_stallE", 32'(stallE), 32'd0);
        check("post_reset_cnt", 32'(stallCount), 32'd0);

        // Saturation under a sustained load-use hazard.
        memToRegE = 1; rwE = 1; wrE = 3; rr1D = 3;
        repeat (20) step();
        check("cnt_saturated", 32'(stallCount), 32'(CMAX));
        clearIn();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Random traffic on a small register window to provoke matches.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            rr1D = RB'($urandom_range(0, 3));
            rr2D = RB'($urandom_range(0, 3));
            rr1E = RB'($urandom_range(0, 3));
            rr2E = RB'($urandom_range(0, 3));
            wrE = RB'($urandom_range(0, 3));
            wrM = RB'($urandom_range(0, 3));
            wrW = RB'($urandom_range(0, 3));
            rwE = 1'($urandom);
            rwM = 1'($urandom);
            rwW = 1'($urandom);
            memToRegE = 1'($urandom);
            branchTakenE = ($urandom_range(0, 3) == 0);
            mdStartE = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
